// File: rtl/calc_driver_pkg.sv
// calc_driver_pkg: shared state encoding, widths, timing defaults and button indices for the front-panel driver
package calc_driver_pkg;
  localparam int CALC_W = 16;
  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_SETTLE_CYC = 3;
  localparam int BTN_L = 2;
  localparam int BTN_C = 1;
  localparam int BTN_R = 0;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_CLR, S_SETTLE, S_RESP} state_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/calc_drv_timer.sv
// calc_drv_timer: loadable down-counter whose done flag is high while the count is zero
module calc_drv_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/calc_driver.sv
// calc_driver: command-driven sequencer that pulses the calculator's buttons and returns the sampled led value
module calc_driver
  import calc_driver_pkg::*;
#(
  parameter int DATA_W     = CALC_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int PULSE_CYC  = DEF_PULSE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clr,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              btnl,
  output logic              btnc,
  output logic              btnr,
  output logic              btnu,
  output logic              btnd,
  output logic [DATA_W-1:0] sw,
  input  logic [DATA_W-1:0] led,
  output logic              busy
);
  localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, SETTLE_CYC) + 1);
  state_t r_state, w_next;
  logic [2:0] r_btn, w_btn;
  logic [DATA_W-1:0] w_sw, w_rsp_data;
  logic [CNT_W-1:0] w_load_val;
  logic w_accept, w_done, w_load;
  assign w_accept = cmd_valid && cmd_ready;
  calc_drv_timer #(.W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_done (w_done)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_btn     <= '0;
      sw        <= '0;
      btnd      <= 1'b0;
      btnu      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      r_state   <= w_next;
      r_btn     <= w_btn;
      sw        <= w_sw;
      btnd      <= (w_next == S_PULSE);
      btnu      <= (w_next == S_CLR);
      cmd_ready <= (w_next == S_IDLE);
      busy      <= (w_next != S_IDLE);
      rsp_valid <= (w_next == S_RESP);
      rsp_data  <= w_rsp_data;
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:         w_next = w_accept ? (cmd_clr ? S_CLR : S_SETUP) : S_IDLE;
      S_SETUP:        w_next = w_done ? S_PULSE : S_SETUP;
      S_PULSE, S_CLR: w_next = w_done ? S_SETTLE : r_state;
      S_SETTLE:       w_next = w_done ? S_RESP : S_SETTLE;
      S_RESP:         w_next = rsp_ready ? S_IDLE : S_RESP;
      default:        w_next = S_IDLE;
    endcase
  end
  // every transition reloads the timer with the new state's length minus one
  always_comb begin
    w_load     = (w_next != r_state);
    w_load_val = (w_next == S_SETUP) ? CNT_W'(SETUP_CYC - 1) :
                 (w_next == S_PULSE || w_next == S_CLR) ? CNT_W'(PULSE_CYC - 1) :
                 (w_next == S_SETTLE) ? CNT_W'(SETTLE_CYC - 1) : '0;
    w_btn      = (w_accept && !cmd_clr) ? cmd_op :
                 (w_next == S_RESP || w_next == S_IDLE) ? 3'b000 : r_btn;
    w_sw       = (w_accept && !cmd_clr) ? cmd_data : sw;
    w_rsp_data = (r_state == S_SETTLE && w_next == S_RESP) ? led : rsp_data;
  end
  assign btnl = r_btn[BTN_L];
  assign btnc = r_btn[BTN_C];
  assign btnr = r_btn[BTN_R];
endmodule

// File: tb/tb_calc_driver.sv
// tb_calc_driver: vector table, directed corner cases and random commands checked against a per-cycle timeline model
module tb_calc_driver;
  localparam int W = 16, S = 2, P = 4, E = 3;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_clr = 1'b0, rsp_ready = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [W-1:0] cmd_data = '0, led = '0;
  logic cmd_ready, rsp_valid, btnl, btnc, btnr, btnu, btnd, busy;
  logic [W-1:0] rsp_data, sw;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  calc_driver dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clr(cmd_clr),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .btnl(btnl), .btnc(btnc), .btnr(btnr), .btnu(btnu), .btnd(btnd),
    .sw(sw), .led(led), .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] flags();
    return {btnl, btnc, btnr, btnd, btnu, cmd_ready, busy, rsp_valid};
  endfunction
  // called at a negedge in IDLE; returns at the negedge after the response handshake
  task automatic run_cmd(input bit clr, input logic [2:0] op, input logic [W-1:0] data,
                         input logic [W-1:0] ledv, input int lat, input int rwait, input bit hold);
    logic [W-1:0] swe;
    logic [2:0] be;
    swe = clr ? sw : data;
    be = clr ? 3'b000 : op;
    led = ledv;
    cmd_valid = 1'b1; cmd_clr = clr; cmd_op = op; cmd_data = data;
    rsp_ready = (rwait < 0);
    chk("idle_ready", flags(), 8'b00000100);
    @(negedge clk);
    cmd_valid = hold; cmd_clr = 1'($urandom); cmd_op = 3'($urandom); cmd_data = W'($urandom);
    for (int k = 1; k < lat; k++) begin
      chk("run_flags", flags(), {be, !clr && k > S && k <= S + P, clr && k <= P, 3'b010});
      chk("run_sw", sw, swe);
      @(negedge clk);
    end
    for (int k = 0; k <= (rwait < 0 ? 0 : rwait); k++) begin
      chk("resp_flags", flags(), 8'b00000011);
      chk("resp_data", rsp_data, ledv);
      chk("resp_sw", sw, swe);
      if (k == rwait) rsp_ready = 1'b1;
      @(negedge clk);
    end
    chk("done_flags", flags(), 8'b00000100);
    rsp_ready = 1'b0;
  endtask
  typedef struct {
    bit clr;
    logic [2:0] op;
    logic [W-1:0] data;
    logic [W-1:0] ledv;
    int lat;
    int rwait;
    bit hold;
  } vec_t;
  vec_t vt[6];
  initial begin
    bit c;
    vt[0] = '{1'b0, 3'b010, 16'h0005, 16'h1234, 10, 0, 1'b0};
    vt[1] = '{1'b1, 3'b111, 16'hFFFF, 16'h0000, 8, 0, 1'b0};
    vt[2] = '{1'b0, 3'b001, 16'hBEEF, 16'hCAFE, 10, 5, 1'b1};
    vt[3] = '{1'b0, 3'b100, 16'h8001, 16'h0F0F, 10, -1, 1'b1};
    vt[4] = '{1'b0, 3'b011, 16'h1357, 16'h2468, 10, -1, 1'b0};
    vt[5] = '{1'b1, 3'b000, 16'h0000, 16'hFFFF, 8, 2, 1'b0};
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_op = 3'b101; cmd_data = 16'hABCD;
    repeat (2) begin
      @(negedge clk);
      chk("rst_flags", flags() & 8'b11111011, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_sw", sw, 0);
      chk("rst_rsp", rsp_data, 0);
    end
    rst_n = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    chk("post_rst", flags(), 8'b00000100);
    for (int i = 0; i < 6; i++)
      run_cmd(vt[i].clr, vt[i].op, vt[i].data, vt[i].ledv, vt[i].lat, vt[i].rwait, vt[i].hold);
    cmd_valid = 1'b1; cmd_clr = 1'b0; cmd_op = 3'b100; cmd_data = 16'h00F0; led = 16'h7777;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_btnd", btnd, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_flags", flags() & 8'b11111011, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_sw", sw, 0);
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("midrst_idle", flags(), 8'b00000100);
    end
    for (int i = 0; i < 24; i++) begin
      c = 1'($urandom_range(0, 1));
      run_cmd(c, 3'($urandom), W'($urandom), W'($urandom), c ? 1 + P + E : 1 + S + P + E,
              int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("final_idle", flags(), 8'b00000100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
